// File: rtl/spi_tx_queue.sv
// ---------------------------------------------------------------------------------------------
// spi_tx_queue
//
// Transmit queue in front of an SPI master. Words written by the host are buffered in a
// circular FIFO. A small sequencer pops one word at a time and presents it on spi_data. It
// then issues a one-cycle spi_start request and follows the master's chip select through one
// low/high cycle before it fetches the next word.
//
// Optional feature (macro SPI_TXQ_TERM_EN):
//   When defined, a terminator word TERM_CHAR is sent once after the last word of each burst,
//   that is when the FIFO has drained after at least one word has been popped. When the macro
//   is undefined, the TERM state and the pending flag do not exist and TERM_CHAR is unused.
//
// Parameters:
//   DATA_WIDTH - width of each queued word and of spi_data
//   DEPTH      - FIFO capacity in words (power of two, >= 2)
//   TERM_CHAR  - terminator word (only used with SPI_TXQ_TERM_EN)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-low reset
//   wr_en      in   push strobe
//   wr_data    in   word to push
//   cs         in   active-low chip select from the SPI master (low = transfer in progress)
//   spi_start  out  one-cycle request to start one word transfer
//   spi_data   out  word being transferred, held from spi_start until the transfer completes
//   full       out  FIFO holds DEPTH words (registered)
//   empty      out  FIFO holds no words (registered)
//   level      out  number of words in the FIFO (registered)
//   overflow   out  one-cycle pulse after a write was dropped because the FIFO was full
//   busy       out  sequencer is not idle
// ---------------------------------------------------------------------------------------------
module spi_tx_queue #(
    parameter int unsigned               DATA_WIDTH = 8,
    parameter int unsigned               DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0]     TERM_CHAR  = DATA_WIDTH'(8'h0D)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         cs,
    output logic                         spi_start,
    output logic [DATA_WIDTH-1:0]        spi_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         busy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = $clog2(DEPTH+1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitLow,
        StWaitHigh
`ifdef SPI_TXQ_TERM_EN
        ,
        StTerm
`endif
    } state_e;

    // -----------------------------------------------------------------------------------------
    // Storage and state
    // -----------------------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]       level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;

    state_e                state_q, state_d;
    logic                  spi_start_q, spi_start_d;
    logic [DATA_WIDTH-1:0] spi_data_q, spi_data_d;

    logic                  push;
    logic                  pop;

`ifdef SPI_TXQ_TERM_EN
    logic                  pending_q, pending_d;
`else
    logic                  unused_term_char;
    assign unused_term_char = ^TERM_CHAR;
`endif

    // A write is judged against the registered full flag, so a pop in the same cycle does not
    // rescue it; the word is dropped and reported one cycle later.
    assign push = wr_en & ~full_q;

    // -----------------------------------------------------------------------------------------
    // FIFO bookkeeping
    // -----------------------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = wr_en & full_q;

        // DEPTH is a power of two, so the natural pointer roll-over wraps DEPTH-1 -> 0.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        level_d = level_q + LvlW'(push) - LvlW'(pop);
        full_d  = (level_d == LvlW'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Transfer sequencer
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        spi_data_d  = spi_data_q;
        pop         = 1'b0;
        // The request is registered, so it appears in the cycle after the START state.
        spi_start_d = (state_q == StStart);
`ifdef SPI_TXQ_TERM_EN
        pending_d   = pending_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (!empty_q) begin
                    pop        = 1'b1;
                    spi_data_d = mem[rd_ptr_q];
                    state_d    = StStart;
                end
            end

            StStart: begin
                state_d = StWaitLow;
            end

            StWaitLow: begin
                if (!cs) begin
                    state_d = StWaitHigh;
                end
            end

            StWaitHigh: begin
                if (cs) begin
`ifdef SPI_TXQ_TERM_EN
                    // Burst drained after real data went out: close it with one terminator.
                    if (empty_q && pending_q) begin
                        state_d = StTerm;
                    end else begin
                        state_d = StIdle;
                    end
`else
                    state_d = StIdle;
`endif
                end
            end

`ifdef SPI_TXQ_TERM_EN
            StTerm: begin
                spi_data_d = TERM_CHAR;
                pending_d  = 1'b0;
                state_d    = StStart;
            end
`endif

            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef SPI_TXQ_TERM_EN
        // Only FIFO pops mark a burst as open; the terminator itself never does.
        if (pop) begin
            pending_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            spi_start_q <= 1'b0;
            spi_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            spi_start_q <= spi_start_d;
            spi_data_q  <= spi_data_d;
        end
    end

`ifdef SPI_TXQ_TERM_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end
`endif

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    assign spi_start = spi_start_q;
    assign spi_data  = spi_data_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_spi_tx_queue.sv
// ---------------------------------------------------------------------------------------------
// tb_spi_tx_queue
//
// Directed bench for spi_tx_queue (DATA_WIDTH=8, DEPTH=16). A small SPI-master model answers
// each spi_start by pulling cs low a few cycles later and releasing it after low_len cycles.
// A monitor records every word presented with spi_start and counts any change of spi_data
// while cs is low during a transfer.
// ---------------------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_tx_queue;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
`ifdef SPI_TXQ_TERM_EN
    localparam int TERM_N = 1;
`else
    localparam int TERM_N = 0;
`endif

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          wr_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          cs      = 1'b1;
    logic          spi_start;
    logic [DW-1:0] spi_data;
    logic          full;
    logic          empty;
    logic [4:0]    level;
    logic          overflow;
    logic          busy;

    // Master model controls
    logic          cs_auto = 1'b0;
    logic          kick    = 1'b0;
    int            low_len = 80;

    // Monitor state
    logic [7:0]    sent[$];
    logic [7:0]    last_word = '0;
    int            unstable  = 0;

    int            n_cmp = 0;
    int            n_mis = 0;

    spi_tx_queue #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .TERM_CHAR  (8'h0D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .cs         (cs),
        .spi_start  (spi_start),
        .spi_data   (spi_data),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // SPI master model: cs low 5 cycles after the request, high again after low_len cycles.
    always begin
        @(negedge clk);
        if (cs_auto && (spi_start === 1'b1 || kick)) begin
            repeat (5) @(posedge clk);
            #1 cs = 1'b0;
            repeat (low_len) @(posedge clk);
            #1 cs = 1'b1;
        end
    end

    // Monitor: log started words, flag data changes inside a cs-low window.
    always @(negedge clk) begin
        if (busy !== 1'b1) begin
            last_word = spi_data;
        end else if (spi_start === 1'b1) begin
            sent.push_back(spi_data);
            last_word = spi_data;
        end else if (cs === 1'b0 && spi_data !== last_word) begin
            unstable++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!(busy === 1'b0 && empty === 1'b1 && cs === 1'b1) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(n < budget), 32'd1);
    endtask

    initial begin
        int base;
        int idx;
        int n;
        logic [7:0] w;
        logic [7:0] got[$];

        // ---------------- reset state ----------------
        repeat (3) tick();
        rst = 1'b1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_spi_start", 32'(spi_start), 32'd0);
        check("rst_spi_data", 32'(spi_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // ---------------- single word, latency ----------------
        cs_auto = 1'b1;
        low_len = 80;
        base    = sent.size();
        write_word(8'h4B);
        check("t1_e0_start", 32'(spi_start), 32'd0);
        check("t1_e0_level", 32'(level), 32'd1);
        check("t1_e0_busy", 32'(busy), 32'd0);
        tick();
        check("t1_e1_start", 32'(spi_start), 32'd0);
        check("t1_e1_busy", 32'(busy), 32'd1);
        check("t1_e1_empty", 32'(empty), 32'd1);
        tick();
        check("t1_e2_start", 32'(spi_start), 32'd1);
        check("t1_e2_data", 32'(spi_data), 32'h4B);
        tick();
        check("t1_e3_start", 32'(spi_start), 32'd0);
        wait_idle("t1", 600);
        check("t1_count", 32'(sent.size() - base), 32'(1 + TERM_N));
        check("t1_word", 32'(sent[base]), 32'h4B);
        if (TERM_N == 1) check("t1_term", 32'(sent[base + 1]), 32'h0D);

        // ---------------- fill to full, overflow ----------------
        // A lead word parks the sequencer in WAIT_LOW (cs held high) so nothing else pops.
        cs_auto = 1'b0;
        base    = sent.size();
        write_word(8'hA5);
        repeat (3) tick();
        check("t2_park_level", 32'(level), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            write_word(8'(i));
        end
        check("t2_full", 32'(full), 32'd1);
        check("t2_level16", 32'(level), 32'd16);
        check("t2_empty", 32'(empty), 32'd0);
        check("t2_no_ovf", 32'(overflow), 32'd0);
        write_word(8'h11);
        check("t2_ovf_pulse", 32'(overflow), 32'd1);
        check("t2_ovf_level", 32'(level), 32'd16);
        tick();
        check("t2_ovf_clear", 32'(overflow), 32'd0);
        check("t2_level_hold", 32'(level), 32'd16);
        low_len = 8;
        cs_auto = 1'b1;
        kick    = 1'b1;
        tick();
        kick    = 1'b0;
        wait_idle("t2", 3000);
        check("t2_count", 32'(sent.size() - base), 32'(17 + TERM_N));
        check("t2_lead", 32'(sent[base]), 32'hA5);
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("t2_word%0d", i), 32'(sent[base + i]), 32'(i));
        end
        if (TERM_N == 1) check("t2_term", 32'(sent[base + 17]), 32'h0D);

        // ---------------- three-word message ----------------
        low_len = 6;
        base    = sent.size();
        write_word(8'h41);
        write_word(8'h42);
        write_word(8'h43);
        wait_idle("t3", 1000);
        check("t3_count", 32'(sent.size() - base), 32'(3 + TERM_N));
        check("t3_w0", 32'(sent[base]), 32'h41);
        check("t3_w1", 32'(sent[base + 1]), 32'h42);
        check("t3_w2", 32'(sent[base + 2]), 32'h43);
        if (TERM_N == 1) check("t3_term", 32'(sent[base + 3]), 32'h0D);

        // ---------------- wrap-around at random rates ----------------
        low_len = 3;
        base    = sent.size();
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 12)) tick();
            n = 0;
            while (full === 1'b1 && n < 500) begin
                tick();
                n++;
            end
            write_word(8'(8'h80 + i));
        end
        wait_idle("t4", 3000);
        for (int i = base; i < sent.size(); i++) begin
            if (sent[i] != 8'h0D) got.push_back(sent[i]);
        end
        check("t4_count", 32'(got.size()), 32'd40);
        for (int i = 0; i < 40; i++) begin
            w = 8'(8'h80 + i);
            check($sformatf("t4_word%0d", i), 32'(got[i]), 32'(w));
        end
        check("t4_empty", 32'(empty), 32'd1);

        // ---------------- reset during WAIT_HIGH ----------------
        cs_auto = 1'b0;
        for (int i = 0; i < 6; i++) begin
            write_word(8'(8'hC0 + i));
        end
        repeat (3) tick();
        check("t5_level5", 32'(level), 32'd5);
        low_len = 50;
        cs_auto = 1'b1;
        kick    = 1'b1;
        tick();
        kick    = 1'b0;
        repeat (10) tick();
        check("t5_busy_pre", 32'(busy), 32'd1);
        check("t5_level_pre", 32'(level), 32'd5);
        idx = sent.size();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t5_level0", 32'(level), 32'd0);
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_full", 32'(full), 32'd0);
        check("t5_data", 32'(spi_data), 32'd0);
        repeat (100) tick();
        check("t5_no_start", 32'(sent.size()), 32'(idx));
        check("t5_still_idle", 32'(busy), 32'd0);
        low_len = 6;
        write_word(8'hD7);
        wait_idle("t5", 1000);
        check("t5_new_count", 32'(sent.size() - idx), 32'(1 + TERM_N));
        check("t5_new_word", 32'(sent[idx]), 32'hD7);

        check("data_stable", 32'(unstable), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
